ro_puf_controller: RTL and testbench

RO_PUF_CONTROLLER -- requirements
Module: ro_puf_controller

---
 rtl/ro_puf_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_ro_puf_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_controller.sv
// Ring-oscillator PUF evaluation sequencer: races one selected RO pair per
// response bit for a fixed window and records which ring produced more edges.
module ro_puf_controller #(
  parameter int NUM_SEL_W = 4,
  parameter int RESP_BITS = 8,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1000,
  parameter int SETTLE    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [RESP_BITS*2*NUM_SEL_W-1:0] challenge,
  input  logic                             ro_a_in,
  input  logic                             ro_b_in,
  output logic                             ro_en,
  output logic [NUM_SEL_W-1:0]             sel_a,
  output logic [NUM_SEL_W-1:0]             sel_b,
  output logic                             busy,
  output logic                             done,
  output logic [RESP_BITS-1:0]             response,
  output logic [RESP_BITS-1:0]             tie_mask
);

  localparam int CH_W   = RESP_BITS * 2 * NUM_SEL_W;
  localparam int IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int PH_MAX = (WINDOW > SETTLE) ? WINDOW : ((SETTLE > 2) ? SETTLE : 2);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE - 1);
  localparam logic [PH_W-1:0]  WINDOW_LAST = PH_W'(WINDOW - 1);
  localparam logic [PH_W-1:0]  DRAIN_LAST  = PH_W'(1);
  localparam logic [IDX_W-1:0] PAIR_LAST   = IDX_W'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Select field of one pair; the {idx, upper} concatenation is the field number.
  function automatic logic [NUM_SEL_W-1:0] pair_sel(input logic [CH_W-1:0]  ch,
                                                    input logic [IDX_W-1:0] idx,
                                                    input logic             upper);
    int base;
    base = int'({idx, upper}) * NUM_SEL_W;
    return ch[base +: NUM_SEL_W];
  endfunction

  // Returns {response_bit, tie_bit}; a pair racing one ring against itself never reports 1.
  function automatic logic [1:0] judge(input logic [CNT_W-1:0]     ca,
                                       input logic [CNT_W-1:0]     cb,
                                       input logic [NUM_SEL_W-1:0] sa,
                                       input logic [NUM_SEL_W-1:0] sb);
    logic same_ro;
    same_ro = (sa == sb);
    return {(!same_ro && (ca > cb)), (same_ro || (ca == cb))};
  endfunction

  state_t                 state_r, state_nxt_s;
  logic [PH_W-1:0]        ph_r;
  logic [IDX_W-1:0]       pair_r, pair_nxt_s;
  logic [CH_W-1:0]        chal_r, chal_nxt_s;
  logic [2:0]             sync_a_r, sync_b_r;
  logic [CNT_W-1:0]       cnt_a_r, cnt_b_r;
  logic                   ro_en_r, busy_r, done_r;
  logic [NUM_SEL_W-1:0]   sel_a_r, sel_b_r;
  logic [RESP_BITS-1:0]   resp_r, tie_r;

  logic                   ph_last_s, busy_state_s, accept_s, kill_s, counting_s;
  logic                   edge_a_s, edge_b_s;
  logic [1:0]             judge_s;
  logic                   ro_en_s, busy_s, done_s;
  logic [NUM_SEL_W-1:0]   sel_a_s, sel_b_s;
  logic [RESP_BITS-1:0]   resp_s, tie_s;

  assign busy_state_s = state_r inside {ST_SETUP, ST_MEASURE, ST_DRAIN, ST_COMPARE};
  assign accept_s     = (state_r == ST_IDLE) && start && !abort;
  assign kill_s       = busy_state_s && abort;
  assign counting_s   = (state_r == ST_MEASURE) || (state_r == ST_DRAIN);
  assign edge_a_s     = sync_a_r[1] & ~sync_a_r[2];
  assign edge_b_s     = sync_b_r[1] & ~sync_b_r[2];
  assign judge_s      = judge(cnt_a_r, cnt_b_r, sel_a_r, sel_b_r);

  // Last cycle of the timed states.
  always_comb begin
    case (state_r)
      ST_SETUP:   ph_last_s = (ph_r == SETTLE_LAST);
      ST_MEASURE: ph_last_s = (ph_r == WINDOW_LAST);
      ST_DRAIN:   ph_last_s = (ph_r == DRAIN_LAST);
      default:    ph_last_s = 1'b1;
    endcase
  end

  // State register and in-state phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ph_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) begin
        ph_r <= '0;
      end else begin
        ph_r <= ph_r + PH_W'(1);
      end
    end
  end

  // Next-state logic; abort from any busy state wins over every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (kill_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_nxt_s = accept_s ? ST_SETUP : ST_IDLE;
        ST_SETUP:   state_nxt_s = ph_last_s ? ST_MEASURE : ST_SETUP;
        ST_MEASURE: state_nxt_s = ph_last_s ? ST_DRAIN : ST_MEASURE;
        ST_DRAIN:   state_nxt_s = ph_last_s ? ST_COMPARE : ST_DRAIN;
        ST_COMPARE: state_nxt_s = (pair_r == PAIR_LAST) ? ST_DONE : ST_SETUP;
        ST_DONE:    state_nxt_s = ST_IDLE;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Pair index and challenge capture.
  always_comb begin
    pair_nxt_s = pair_r;
    chal_nxt_s = chal_r;
    if (accept_s) begin
      pair_nxt_s = '0;
      chal_nxt_s = challenge;
    end else if ((state_r == ST_COMPARE) && (state_nxt_s == ST_SETUP)) begin
      pair_nxt_s = pair_r + IDX_W'(1);
    end else begin
      pair_nxt_s = pair_r;
    end
  end

  // Output values for the coming state so the registered outputs line up with it.
  always_comb begin
    ro_en_s = (state_nxt_s == ST_MEASURE);
    busy_s  = state_nxt_s inside {ST_SETUP, ST_MEASURE, ST_DRAIN, ST_COMPARE};
    done_s  = (state_nxt_s == ST_DONE);
    if (state_nxt_s == ST_SETUP) begin
      sel_a_s = pair_sel(chal_nxt_s, pair_nxt_s, 1'b0);
      sel_b_s = pair_sel(chal_nxt_s, pair_nxt_s, 1'b1);
    end else begin
      sel_a_s = sel_a_r;
      sel_b_s = sel_b_r;
    end
  end

  // Response accumulation: cleared on accept or abort, one bit written per COMPARE.
  always_comb begin
    resp_s = resp_r;
    tie_s  = tie_r;
    if (accept_s || kill_s) begin
      resp_s = '0;
      tie_s  = '0;
    end else if (state_r == ST_COMPARE) begin
      resp_s[pair_r] = judge_s[1];
      tie_s[pair_r]  = judge_s[0];
    end else begin
      resp_s = resp_r;
    end
  end

  // Sequencing registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_r  <= '0;
      chal_r  <= '0;
      ro_en_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sel_a_r <= '0;
      sel_b_r <= '0;
      resp_r  <= '0;
      tie_r   <= '0;
    end else begin
      pair_r  <= pair_nxt_s;
      chal_r  <= chal_nxt_s;
      ro_en_r <= ro_en_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      sel_a_r <= sel_a_s;
      sel_b_r <= sel_b_s;
      resp_r  <= resp_s;
      tie_r   <= tie_s;
    end
  end

  // Two synchronizer flops plus one history flop per ring for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_r <= 3'b000;
      sync_b_r <= 3'b000;
    end else begin
      sync_a_r <= {sync_a_r[1:0], ro_a_in};
      sync_b_r <= {sync_b_r[1:0], ro_b_in};
    end
  end

  // Saturating edge counters; DRAIN keeps counting edges still inside the synchronizers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_r <= '0;
      cnt_b_r <= '0;
    end else if (state_r == ST_SETUP) begin
      cnt_a_r <= '0;
      cnt_b_r <= '0;
    end else if (counting_s) begin
      if (edge_a_s && (cnt_a_r != CNT_MAX)) begin
        cnt_a_r <= cnt_a_r + CNT_W'(1);
      end else begin
        cnt_a_r <= cnt_a_r;
      end
      if (edge_b_s && (cnt_b_r != CNT_MAX)) begin
        cnt_b_r <= cnt_b_r + CNT_W'(1);
      end else begin
        cnt_b_r <= cnt_b_r;
      end
    end else begin
      cnt_a_r <= cnt_a_r;
      cnt_b_r <= cnt_b_r;
    end
  end

  assign ro_en    = ro_en_r;
  assign sel_a    = sel_a_r;
  assign sel_b    = sel_b_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign response = resp_r;
  assign tie_mask = tie_r;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Randomized bench for ro_puf_controller: two instances (normal counters and a
// narrow saturating one) share stimulus and are checked against a timeline model.
module tb_ro_puf_controller;

  localparam int NW   = 2;
  localparam int RB   = 4;
  localparam int S    = 2;
  localparam int CH_W = RB * 2 * NW;
  localparam int W0   = 20;
  localparam int W1   = 40;
  localparam int MAXC = 40000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ro_a = 1'b0;
  logic ro_b = 1'b0;
  logic [CH_W-1:0] challenge = '0;

  logic [1:0]         ro_en_v, busy_v, done_v;
  logic [1:0][NW-1:0] sel_a_v, sel_b_v;
  logic [1:0][RB-1:0] resp_v, tie_v;

  int checks = 0;
  int errors = 0;

  ro_puf_controller #(.NUM_SEL_W(NW), .RESP_BITS(RB), .CNT_W(8), .WINDOW(W0), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .challenge(challenge),
    .ro_a_in(ro_a), .ro_b_in(ro_b), .ro_en(ro_en_v[0]), .sel_a(sel_a_v[0]), .sel_b(sel_b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .response(resp_v[0]), .tie_mask(tie_v[0]));

  ro_puf_controller #(.NUM_SEL_W(NW), .RESP_BITS(RB), .CNT_W(3), .WINDOW(W1), .SETTLE(S)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .challenge(challenge),
    .ro_a_in(ro_a), .ro_b_in(ro_b), .ro_en(ro_en_v[1]), .sel_a(sel_a_v[1]), .sel_b(sel_b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .response(resp_v[1]), .tie_mask(tie_v[1]));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] ch_sel(input logic [CH_W-1:0] ch, input int pair, input int upper);
    logic [CH_W-1:0] t;
    t = ch >> ((2 * pair + upper) * NW);
    return t[NW-1:0];
  endfunction

  function automatic logic [CH_W-1:0] mkch(input int pa[RB], input int pb[RB]);
    logic [CH_W-1:0] c;
    c = '0;
    for (int i = 0; i < RB; i++) begin
      c[(2*i)*NW +: NW]   = NW'(pa[i]);
      c[(2*i+1)*NW +: NW] = NW'(pb[i]);
    end
    return c;
  endfunction

  // ---------------- reference model ----------------
  // ha/hb hold the ring value seen by the first synchronizer flop at each edge;
  // an edge becomes visible to the counter two clocks after it is sampled.
  bit ha[MAXC];
  bit hb[MAXC];
  int cyc = 0;
  int win[2]  = '{W0, W1};
  int cmax[2] = '{255, 7};
  bit act[2];
  int tacc[2];
  logic [CH_W-1:0] mch[2];
  logic [RB-1:0] mresp[2], mtie[2];
  bit e_busy[2], e_en[2], e_done[2];
  logic [NW-1:0] e_sa[2], e_sb[2];
  int dcnt[2];
  bit armed = 1'b0;

  function automatic int count_edges(input bit is_b, input int first, input int last, input int cap);
    int n;
    bit cur, old;
    n = 0;
    for (int k = first; k <= last; k++) begin
      cur = is_b ? hb[k-1] : ha[k-1];
      old = is_b ? hb[k-2] : ha[k-2];
      if (cur && !old) n++;
    end
    return (n > cap) ? cap : n;
  endfunction

  always @(posedge clk) begin
    int per, offp, off, j, base, ca, cb;
    logic [NW-1:0] sa, sb;
    cyc++;
    ha[cyc] = rst_n ? ro_a : 1'b0;
    hb[cyc] = rst_n ? ro_b : 1'b0;
    armed = 1'b1;
    for (int i = 0; i < 2; i++) begin
      per = S + win[i] + 3;
      if (!rst_n) begin
        act[i] = 1'b0; mresp[i] = '0; mtie[i] = '0;
      end else if (act[i]) begin
        offp = cyc - 1 - tacc[i];
        if (offp < RB * per && abort) begin
          act[i] = 1'b0; mresp[i] = '0; mtie[i] = '0;
        end else if (offp >= RB * per) begin
          act[i] = 1'b0;
        end else if (offp % per == per - 1) begin
          j    = offp / per;
          base = tacc[i] + j * per;
          ca   = count_edges(1'b0, base + S, base + S + win[i] + 1, cmax[i]);
          cb   = count_edges(1'b1, base + S, base + S + win[i] + 1, cmax[i]);
          sa   = ch_sel(mch[i], j, 0);
          sb   = ch_sel(mch[i], j, 1);
          mresp[i][j] = (sa != sb) && (ca > cb);
          mtie[i][j]  = (sa == sb) || (ca == cb);
        end
      end else if (start && !abort) begin
        act[i] = 1'b1; tacc[i] = cyc; mch[i] = challenge; mresp[i] = '0; mtie[i] = '0;
      end
      off       = cyc - tacc[i];
      e_busy[i] = act[i] && (off < RB * per);
      e_done[i] = act[i] && (off == RB * per);
      e_en[i]   = e_busy[i] && (off % per >= S) && (off % per < S + win[i]);
      e_sa[i]   = ch_sel(mch[i], off / per, 0);
      e_sb[i]   = ch_sel(mch[i], off / per, 1);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        if (done_v[i]) dcnt[i]++;
        chk("busy",  i, 32'(busy_v[i]),  rst_n ? 32'(e_busy[i]) : 32'd0);
        chk("ro_en", i, 32'(ro_en_v[i]), rst_n ? 32'(e_en[i])   : 32'd0);
        chk("done",  i, 32'(done_v[i]),  rst_n ? 32'(e_done[i]) : 32'd0);
        chk("response", i, 32'(resp_v[i]), rst_n ? 32'(mresp[i]) : 32'd0);
        chk("tie_mask", i, 32'(tie_v[i]),  rst_n ? 32'(mtie[i])  : 32'd0);
        if (rst_n && e_en[i]) begin
          chk("sel_a", i, 32'(sel_a_v[i]), 32'(e_sa[i]));
          chk("sel_b", i, 32'(sel_b_v[i]), 32'(e_sb[i]));
        end
      end
    end
  end

  // ---------------- ring oscillator stimulus ----------------
  // mode 0: low, 1: clk/4, 2: clk/8, 3: random half-periods of 2..5 cycles
  int mode_a = 0, mode_b = 0, ph = 0, ra = 2, rb = 3;

  initial begin
    forever begin
      @(negedge clk);
      ph++;
      case (mode_a)
        0: ro_a = 1'b0;
        1: ro_a = ph[1];
        2: ro_a = ph[2];
        default: begin ra--; if (ra <= 0) begin ro_a = ~ro_a; ra = $urandom_range(2, 5); end end
      endcase
      case (mode_b)
        0: ro_b = 1'b0;
        1: ro_b = ph[1];
        2: ro_b = ph[2];
        default: begin rb--; if (rb <= 0) begin ro_b = ~ro_b; rb = $urandom_range(2, 5); end end
      endcase
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((act[0] || act[1]) && n < 1000) begin @(negedge clk); n++; end
    if (act[0] || act[1]) begin
      errors++;
      $display("FAIL idle_timeout: evaluation still running after %0d cycles", n);
    end
    @(negedge clk);
  endtask

  // Starts one evaluation and returns the number of rising edges from the
  // accept edge through the edge at which done is first captured, inclusive.
  task automatic run_eval(input logic [CH_W-1:0] ch, output int lat);
    @(negedge clk); challenge = ch; start = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); start = 1'b0; challenge = CH_W'($urandom);
    while (!done_v[0] && lat < 400) begin @(posedge clk); lat++; @(negedge clk); end
    if (!done_v[0]) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end
    wait_idle();
  endtask

  initial begin
    int lat, d0, d1;
    logic [CH_W-1:0] ch_main, ch_tie;
    ch_main = mkch('{1, 0, 2, 3}, '{2, 3, 1, 0});
    ch_tie  = mkch('{2, 0, 1, 3}, '{2, 1, 3, 2});

    // reset state
    @(negedge clk);
    chk("rst_busy",  0, 32'(busy_v),  32'd0);
    chk("rst_ro_en", 0, 32'(ro_en_v), 32'd0);
    chk("rst_done",  0, 32'(done_v),  32'd0);
    chk("rst_resp",  0, 32'(resp_v),  32'd0);
    chk("rst_tie",   0, 32'(tie_v),   32'd0);
    chk("rst_sel",   0, 32'({sel_a_v, sel_b_v}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // clk/4 vs clk/8 on distinct pairs: every bit favours ring a
    mode_a = 1; mode_b = 2;
    run_eval(ch_main, lat);
    chk("latency", 0, 32'(lat), 32'd101);
    chk("resp_fast_a", 0, 32'(resp_v[0]), 32'(4'b1111));
    chk("tie_fast_a",  0, 32'(tie_v[0]),  32'(4'b0000));
    chk("resp_fast_a_sat", 1, 32'(resp_v[1]), 32'(4'b1111));

    // identical waveforms: every pair ties, the self-pair reports 0
    mode_a = 1; mode_b = 1;
    run_eval(ch_tie, lat);
    chk("resp_equal", 0, 32'(resp_v[0]), 32'(4'b0000));
    chk("tie_equal",  0, 32'(tie_v[0]),  32'(4'b1111));

    // saturation: narrow counter pins at 7 while ring b stays idle
    mode_a = 1; mode_b = 0;
    run_eval(ch_main, lat);
    chk("resp_sat", 1, 32'(resp_v[1]), 32'(4'b1111));
    chk("tie_sat",  1, 32'(tie_v[1]),  32'(4'b0000));

    // randomized traffic
    for (int t = 0; t < 8; t++) begin
      mode_a = $urandom_range(0, 3); mode_b = $urandom_range(0, 3);
      run_eval(CH_W'($urandom), lat);
    end

    // abort during the measurement window of pair 1
    mode_a = 1; mode_b = 3;
    d0 = dcnt[0]; d1 = dcnt[1];
    @(negedge clk); challenge = ch_main; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (31) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy",  0, 32'(busy_v),  32'd0);
    chk("abort_ro_en", 0, 32'(ro_en_v), 32'd0);
    chk("abort_resp",  0, 32'(resp_v),  32'd0);
    repeat (200) @(negedge clk);
    chk("abort_no_done", 0, 32'(dcnt[0] - d0), 32'd0);
    chk("abort_no_done", 1, 32'(dcnt[1] - d1), 32'd0);
    run_eval(ch_main, lat);
    chk("after_abort_latency", 0, 32'(lat), 32'd101);

    // start pulses while busy are ignored
    d0 = dcnt[0]; d1 = dcnt[1];
    @(negedge clk); challenge = ch_tie; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      repeat (20) @(negedge clk);
      start = 1'b1; challenge = CH_W'($urandom);
      @(negedge clk); start = 1'b0;
    end
    wait_idle();
    chk("one_done_per_accept", 0, 32'(dcnt[0] - d0), 32'd1);
    chk("one_done_per_accept", 1, 32'(dcnt[1] - d1), 32'd1);

    // reset asserted mid-cycle during DRAIN of pair 0
    @(negedge clk); challenge = ch_main; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (22) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  0, 32'(busy_v),  32'd0);
    chk("mid_rst_ro_en", 0, 32'(ro_en_v), 32'd0);
    chk("mid_rst_out",   0, 32'({done_v, resp_v, tie_v}), 32'd0);
    chk("mid_rst_sel",   0, 32'({sel_a_v, sel_b_v}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", 0, 32'(busy_v), 32'd0);
    mode_a = 3; mode_b = 3;
    run_eval(CH_W'($urandom), lat);
    chk("post_rst_latency", 0, 32'(lat), 32'd101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
